// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite register-slave definitions: response codes and FSM state types.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

endpackage

// File: rtl/axi_lite_reg_bank.sv
// Register storage with byte-strobe merge on a single write port and a flat read-out.
module axi_lite_reg_bank #(
  parameter int IDX_W    = 3,
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_we,
  input  logic [IDX_W-1:0]           i_idx,
  input  logic [DATA_W-1:0]          i_wdata,
  input  logic [DATA_W/8-1:0]        i_wstrb,
  output logic [NUM_REGS*DATA_W-1:0] o_regs
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];

  // NOTE: this storage is architecturally visible on o_regs, so unlike a RAM it must be cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) r_mem[r] <= '0;
    end else if (i_we) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        for (int b = 0; b < DATA_W/8; b++) begin
          if (i_idx == IDX_W'(r) && i_wstrb[b]) r_mem[r][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign o_regs[g*DATA_W +: DATA_W] = r_mem[g];
  end

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers; independent write and read FSMs.
module axi_lite_slave_regs
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       awvalid,
  output logic                       awready,
  input  logic [ADDR_W-1:0]          awaddr,
  input  logic                       wvalid,
  output logic                       wready,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [DATA_W/8-1:0]        wstrb,
  output logic                       bvalid,
  input  logic                       bready,
  output logic [1:0]                 bresp,
  input  logic                       arvalid,
  output logic                       arready,
  input  logic [ADDR_W-1:0]          araddr,
  output logic                       rvalid,
  input  logic                       rready,
  output logic [DATA_W-1:0]          rdata,
  output logic [1:0]                 rresp,
  output logic [NUM_REGS*DATA_W-1:0] regs_o
);

  localparam int IDX_W  = ADDR_W - 2;
  localparam int STRB_W = DATA_W / 8;
  localparam logic [IDX_W:0] IDX_LIMIT = NUM_REGS[IDX_W:0];

  w_state_e r_wstate, w_wstate_nxt;
  r_state_e r_rstate, w_rstate_nxt;
  logic                       r_active;
  logic [ADDR_W-1:0]          r_awaddr;
  logic [DATA_W-1:0]          r_wdata;
  logic [STRB_W-1:0]          r_wstrb;
  logic [1:0]                 r_bresp, r_rresp;
  logic [DATA_W-1:0]          r_rdata;

  logic                       w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_wr_ok, w_rd_ok;
  logic [ADDR_W-1:0]          w_cmt_addr;
  logic [DATA_W-1:0]          w_cmt_data, w_rd_val;
  logic [STRB_W-1:0]          w_cmt_strb;
  logic [IDX_W-1:0]           w_wr_idx, w_rd_idx;
  logic [NUM_REGS*DATA_W-1:0] w_regs;

  // r_active holds the readies low on the reset edge and releases them on the first edge out of reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
      r_active <= 1'b0;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_rstate <= w_rstate_nxt;
      r_active <= 1'b1;
    end
  end

  // NOTE: each combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) w_wstate_nxt = W_RESP;
        else if (w_aw_hs)      w_wstate_nxt = W_HAVE_AW;
        else if (w_w_hs)       w_wstate_nxt = W_HAVE_W;
      end
      W_HAVE_AW: if (w_w_hs)  w_wstate_nxt = W_RESP;
      W_HAVE_W:  if (w_aw_hs) w_wstate_nxt = W_RESP;
      W_RESP:    if (bready)  w_wstate_nxt = W_IDLE;
      default:                w_wstate_nxt = W_IDLE;
    endcase
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
      R_DATA:  if (rready)  w_rstate_nxt = R_IDLE;
      default:              w_rstate_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    awready = r_active && (r_wstate == W_IDLE || r_wstate == W_HAVE_W);
    wready  = r_active && (r_wstate == W_IDLE || r_wstate == W_HAVE_AW);
    bvalid  = (r_wstate == W_RESP);
    arready = r_active && (r_rstate == R_IDLE);
    rvalid  = (r_rstate == R_DATA);
  end

  assign w_aw_hs    = awvalid && awready;
  assign w_w_hs     = wvalid && wready;
  assign w_ar_hs    = arvalid && arready;
  // A write commits on the edge that first enters W_RESP, using whichever half arrives this cycle.
  assign w_commit   = (r_wstate != W_RESP) && (w_wstate_nxt == W_RESP);
  assign w_cmt_addr = w_aw_hs ? awaddr : r_awaddr;
  assign w_cmt_data = w_w_hs ? wdata : r_wdata;
  assign w_cmt_strb = w_w_hs ? wstrb : r_wstrb;
  assign w_wr_idx   = w_cmt_addr[ADDR_W-1:2];
  assign w_rd_idx   = araddr[ADDR_W-1:2];
  assign w_wr_ok    = {1'b0, w_wr_idx} < IDX_LIMIT;
  assign w_rd_ok    = {1'b0, w_rd_idx} < IDX_LIMIT;

  always_comb begin
    w_rd_val = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (w_rd_idx == IDX_W'(r)) w_rd_val = w_regs[r*DATA_W +: DATA_W];
    end
  end

  // Held address/data are only consumed after a handshake, so they need no reset.
  always_ff @(posedge clk) begin
    if (w_aw_hs) r_awaddr <= awaddr;
    if (w_w_hs) begin
      r_wdata <= wdata;
      r_wstrb <= wstrb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bresp <= RESP_OKAY;
      r_rresp <= RESP_OKAY;
      r_rdata <= '0;
    end else begin
      if (w_commit) r_bresp <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
      if (w_ar_hs) begin
        r_rdata <= w_rd_ok ? w_rd_val : '0;
        r_rresp <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  axi_lite_reg_bank #(
    .IDX_W    (IDX_W),
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_commit && w_wr_ok),
    .i_idx   (w_wr_idx),
    .i_wdata (w_cmt_data),
    .i_wstrb (w_cmt_strb),
    .o_regs  (w_regs)
  );

  assign bresp  = r_bresp;
  assign rdata  = r_rdata;
  assign rresp  = r_rresp;
  assign regs_o = w_regs;

endmodule

// File: doc/axi_lite_slave_regs.md
AXI_LITE_SLAVE_REGS -- requirements
Module: axi_lite_slave_regs

Interface
REQ-001 SHALL have parameter: ADDR_W, 5, byte-address width.
REQ-002 SHALL have parameter: DATA_W, 32, data width; only 32 is supported.
REQ-003 SHALL have parameter: NUM_REGS, 4, number of 32-bit registers; NUM_REGS*4 <= 2**ADDR_W.
REQ-004 SHALL have ports:
  clk  in  1  sole clock, rising edge
  rst  in  1  synchronous reset, active-high
  awvalid  in  1  write address valid
  awready  out  1  write address ready
  awaddr  in  ADDR_W  write byte address
  wvalid  in  1  write data valid
  wready  out  1  write data ready
  wdata  in  DATA_W  write data
  wstrb  in  DATA_W/8  byte strobes
  bvalid  out  1  write response valid
  bready  in  1  write response ready
  bresp  out  2  write response
  arvalid  in  1  read address valid
  arready  out  1  read address ready
  araddr  in  ADDR_W  read byte address
  rvalid  out  1  read data valid
  rready  in  1  read data ready
  rdata  out  DATA_W  read data
  rresp  out  2  read response
  regs_o  out  NUM_REGS*DATA_W  register contents, reg0 in LSBs

Function
REQ-005 SHALL decode index = addr[ADDR_W-1:2]; addr[1:0] ignored; index >= NUM_REGS is out of range.
REQ-006 SHALL run a write FSM with states W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
REQ-007 SHALL drive awready=1 in W_IDLE and W_HAVE_W; wready=1 in W_IDLE and W_HAVE_AW; both 0 in W_RESP, so a rising awvalid is accepted in the same cycle.
REQ-008 SHALL capture address/data on each handshake (valid&&ready) and move W_IDLE->W_HAVE_AW (AW only), W_IDLE->W_HAVE_W (W only), or any state->W_RESP once both are held, including both in the same cycle.
REQ-009 SHALL commit the write on the edge entering W_RESP, updating only bytes with wstrb=1, and assert bvalid from that edge (one cycle after the final handshake).
REQ-010 SHALL set bresp=2'b00 (OKAY) in range, 2'b10 (SLVERR) out of range with no register change, and wstrb=0 in range gives OKAY with no change.
REQ-011 SHALL hold bvalid and bresp stable until bready; on bvalid&&bready, go to W_IDLE and drop bvalid the next cycle.
REQ-012 SHALL run a read FSM with states R_IDLE and R_DATA; arready=1 only in R_IDLE.
REQ-013 SHALL register rdata/rresp on the AR handshake (cycle N) and assert rvalid at N+1; out-of-range reads give rdata=0 and rresp=2'b10.
REQ-014 SHALL hold rvalid, rdata and rresp stable until rready, then return to R_IDLE; the next AR can be accepted the cycle after the handshake.
REQ-015 SHALL run read and write paths independently; a read handshake in the same cycle as a write commit to the same index returns the pre-write value.
REQ-016 SHALL drive regs_o directly from the register flops, with no added latency.

Reset
REQ-017 SHALL, while rst=1 at a clock edge, clear all registers to 0, return both FSMs to idle, and drop any pending transaction.
REQ-018 SHALL hold these output values from that edge: awready=0, wready=0, arready=0, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
REQ-019 SHALL restore awready/wready/arready=1 on the first edge with rst=0; a reset mid-transaction discards it with no response issued.

Structure
REQ-020 SHALL place RESP_OKAY, RESP_SLVERR and the write/read FSM state enums in shared package axi_lite_pkg.
REQ-021 SHALL isolate the storage and strobe-merge logic in one sub-module, axi_lite_reg_bank (write port: index, data, strobe, enable; flat read-out).

Verification
REQ-022 Single write: AW 0x04 with W 0xDEADBEEF, wstrb=0xF, same cycle -> bvalid next cycle, bresp=00, regs_o[63:32]=0xDEADBEEF.
REQ-023 Split order: W 0x11223344 at cycle 0, AW 0x08 at cycle 3 -> bvalid at cycle 4; then wstrb=0x3 write 0xFFFFFFFF to 0x08 -> reg2=0x1122FFFF.
REQ-024 Back-pressure: bready low 5 cycles -> bvalid/bresp stable, awready=wready=0; on bready=1, bvalid drops next cycle.
REQ-025 Read: AR 0x04 after REQ-022 -> rvalid next cycle, rdata=0xDEADBEEF, rresp=00; AR 0x10 -> rdata=0, rresp=10.
REQ-026 Collision/out-of-range: read 0x0C in the same cycle as a write commit of 0x5A5A5A5A to 0x0C -> old value returned; write to 0x1C -> bresp=10, regs unchanged.
REQ-027 Reset mid-op: rst=1 while bvalid pending -> bvalid=0 and regs_o=0 at that edge; awready=1 one cycle after rst falls.
